// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one cv32e40p multiplier between NUM_REQ requesters.
// Optional watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; grant and accept happen combinationally
// BUSY  | latched operands held on the multiplier until mul_ready_i
// RESP  | result presented to the winner until its resp_ready_i
module mul_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int OP_W    = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*OP_W-1:0]    req_operator_i,
    input  logic [NUM_REQ*32-1:0]      req_op_a_i,
    input  logic [NUM_REQ*32-1:0]      req_op_b_i,
    input  logic [NUM_REQ*32-1:0]      req_op_c_i,
    input  logic [NUM_REQ*5-1:0]       req_imm_i,
    input  logic [NUM_REQ*2-1:0]       req_short_signed_i,
    output logic [NUM_REQ-1:0]         resp_valid_o,
    input  logic [NUM_REQ-1:0]         resp_ready_i,
    output logic [31:0]                resp_result_o,
    output logic                       resp_err_o,
    output logic                       mul_enable_o,
    output logic                       mul_ex_ready_o,
    output logic [OP_W-1:0]            mul_operator_o,
    output logic [31:0]                mul_op_a_o,
    output logic [31:0]                mul_op_b_o,
    output logic [31:0]                mul_op_c_o,
    output logic [4:0]                 mul_imm_o,
    output logic [1:0]                 mul_short_signed_o,
    input  logic [31:0]                mul_result_i,
    input  logic                       mul_ready_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d, gnt_q, gnt_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [31:0]      a_q, a_d, b_q, b_d, c_q, c_d, result_q, result_d;
    logic [4:0]       imm_q, imm_d;
    logic [1:0]       ss_q, ss_d;
    logic             err_q, err_d;

    logic             found;
    logic [IDX_W-1:0] pick;
    int               idx;
    int               p;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Search from the slot after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        imm_d    = imm_q;
        ss_d     = ss_q;
        result_d = result_q;
        err_d    = err_q;
        p        = int'(pick);
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_d    = CNT_W'(TIMEOUT - 1);
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    op_d    = req_operator_i[p*OP_W +: OP_W];
                    a_d     = req_op_a_i[p*32 +: 32];
                    b_d     = req_op_b_i[p*32 +: 32];
                    c_d     = req_op_c_i[p*32 +: 32];
                    imm_d   = req_imm_i[p*5 +: 5];
                    ss_d    = req_short_signed_i[p*2 +: 2];
                    gnt_d   = pick;
                    rr_d    = pick;
                    err_d   = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mul_ready_i) begin
                    result_d = mul_result_i;
                    state_d  = RESP;
                end
`ifdef MUL_ARB_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    result_d = 32'hDEAD_BEEF;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            RESP: begin
                if (resp_ready_i[gnt_q]) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= IDX_W'(NUM_REQ - 1);
            gnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            imm_q    <= '0;
            ss_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            imm_q    <= imm_d;
            ss_q     <= ss_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign req_ready_o        = (state_q == IDLE && found) ? (ONE << pick) : '0;
    assign resp_valid_o       = (state_q == RESP) ? (ONE << gnt_q) : '0;
    assign resp_result_o      = result_q;
`ifdef MUL_ARB_TIMEOUT_EN
    assign resp_err_o         = err_q && (state_q == RESP);
`else
    assign resp_err_o         = 1'b0;
`endif
    assign mul_enable_o       = (state_q == BUSY);
    assign mul_ex_ready_o     = (state_q == BUSY);
    assign mul_operator_o     = op_q;
    assign mul_op_a_o         = a_q;
    assign mul_op_b_o         = b_q;
    assign mul_op_c_o         = c_q;
    assign mul_imm_o          = imm_q;
    assign mul_short_signed_o = ss_q;
    assign busy_o             = (state_q != IDLE);
    assign grant_idx_o        = gnt_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: vector table plus hand-written corner sequences.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 2;
    localparam int OP_W    = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic [NUM_REQ*OP_W-1:0] req_operator_i;
    logic [NUM_REQ*32-1:0]   req_op_a_i, req_op_b_i, req_op_c_i;
    logic [NUM_REQ*5-1:0]    req_imm_i;
    logic [NUM_REQ*2-1:0]    req_short_signed_i;
    logic [NUM_REQ-1:0]      resp_valid_o;
    logic [NUM_REQ-1:0]      resp_ready_i;
    logic [31:0]             resp_result_o;
    logic                    resp_err_o;
    logic                    mul_enable_o, mul_ex_ready_o;
    logic [OP_W-1:0]         mul_operator_o;
    logic [31:0]             mul_op_a_o, mul_op_b_o, mul_op_c_o;
    logic [4:0]              mul_imm_o;
    logic [1:0]              mul_short_signed_o;
    logic [31:0]             mul_result_i;
    logic                    mul_ready_i;
    logic                    busy_o;
    logic [0:0]              grant_idx_o;

    mul_share_arbiter #(.NUM_REQ(NUM_REQ), .OP_W(OP_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_operator_i(req_operator_i),
        .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_op_c_i(req_op_c_i),
        .req_imm_i(req_imm_i), .req_short_signed_i(req_short_signed_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_result_o(resp_result_o), .resp_err_o(resp_err_o),
        .mul_enable_o(mul_enable_o), .mul_ex_ready_o(mul_ex_ready_o),
        .mul_operator_o(mul_operator_o),
        .mul_op_a_o(mul_op_a_o), .mul_op_b_o(mul_op_b_o), .mul_op_c_o(mul_op_c_o),
        .mul_imm_o(mul_imm_o), .mul_short_signed_o(mul_short_signed_o),
        .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i),
        .busy_o(busy_o), .grant_idx_o(grant_idx_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  mask;
        logic [2:0]  op;
        logic [31:0] a0, b0, a1, b1;
        int          lat;
        int          gnt;
        logic [31:0] res;
        int          stall;
    } vec_t;

    task automatic run_vec(input vec_t v);
        logic [31:0] ea, eb;
        logic [1:0]  oh;
        ea = (v.gnt == 0) ? v.a0 : v.a1;
        eb = (v.gnt == 0) ? v.b0 : v.b1;
        oh = 2'b01 << v.gnt;
        @(negedge clk);
        req_valid_i    = v.mask;
        req_operator_i = {v.op, v.op};
        req_op_a_i     = {v.a1, v.a0};
        req_op_b_i     = {v.b1, v.b0};
        #1 chk("accept_ready", 32'(req_ready_o), 32'(oh));
        @(posedge clk);
        #1 req_valid_i = '0;
        @(negedge clk);
        for (int c = 1; c <= v.lat; c++) begin
            chk("busy_en", 32'(mul_enable_o), 32'd1);
            chk("busy_exrdy", 32'(mul_ex_ready_o), 32'd1);
            chk("busy_a", mul_op_a_o, ea);
            chk("busy_b", mul_op_b_o, eb);
            if (c == v.lat) begin
                mul_ready_i  = 1'b1;
                mul_result_i = v.res;
            end
            @(negedge clk);
            mul_ready_i  = 1'b0;
            mul_result_i = '0;
        end
        chk("resp_valid", 32'(resp_valid_o), 32'(oh));
        chk("resp_result", resp_result_o, v.res);
        chk("resp_en_low", 32'(mul_enable_o), 32'd0);
        chk("grant_idx", 32'(grant_idx_o), 32'(v.gnt));
        chk("mul_operator", 32'(mul_operator_o), 32'(v.op));
        chk("mul_imm", 32'(mul_imm_o), 32'(v.gnt + 3));
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(resp_valid_o), 32'(oh));
            chk("stall_result", resp_result_o, v.res);
        end
        resp_ready_i = oh;
        @(negedge clk);
        resp_ready_i = '0;
        chk("back_idle", 32'(busy_o), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected end by 200000");
        $fatal(1, "timeout");
    end

    initial begin
        // Grants after reset with rr=1 must go 0,1,0,1 under contention.
        vecs[0] = '{2'b11, 3'd0, 32'd3, 32'd5, 32'd10, 32'd20, 1, 0, 32'd15, 0};
        vecs[1] = '{2'b11, 3'd0, 32'd3, 32'd5, 32'd10, 32'd20, 1, 1, 32'd200, 0};
        vecs[2] = '{2'b11, 3'd0, 32'd3, 32'd5, 32'd10, 32'd20, 1, 0, 32'd15, 0};
        vecs[3] = '{2'b11, 3'd0, 32'd3, 32'd5, 32'd10, 32'd20, 1, 1, 32'd200, 0};
        vecs[4] = '{2'b01, 3'd0, 32'd7, 32'd6, 32'd0, 32'd0, 1, 0, 32'd42, 0};
        vecs[5] = '{2'b10, 3'd6, 32'd0, 32'd0, 32'h0001_0000, 32'h0001_0000, 5, 1, 32'h0000_0001, 0};
        vecs[6] = '{2'b01, 3'd0, 32'd11, 32'd11, 32'd0, 32'd0, 2, 0, 32'd121, 2};

        rst_n              = 1'b0;
        req_valid_i        = '0;
        req_operator_i     = '0;
        req_op_a_i         = '0;
        req_op_b_i         = '0;
        req_op_c_i         = '0;
        req_imm_i          = {5'd4, 5'd3};
        req_short_signed_i = {2'd2, 2'd1};
        resp_ready_i       = '0;
        mul_result_i       = '0;
        mul_ready_i        = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_grant", 32'(grant_idx_o), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_en", 32'(mul_enable_o), 32'd0);
        chk("rst_op_a", mul_op_a_o, 32'd0);
        chk("rst_result", resp_result_o, 32'd0);
        chk("rst_err", 32'(resp_err_o), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Backpressure: req1 served, req0 waits; req0's ready must not count for req1.
        @(negedge clk);
        req_valid_i = 2'b10;
        req_op_a_i  = {32'd9, 32'd2};
        req_op_b_i  = {32'd9, 32'd2};
        #1 chk("bp_accept", 32'(req_ready_o), 32'b10);
        @(posedge clk);
        #1 req_valid_i = '0;
        @(negedge clk);
        mul_ready_i  = 1'b1;
        mul_result_i = 32'd81;
        @(negedge clk);
        mul_ready_i  = 1'b0;
        mul_result_i = '0;
        req_valid_i  = 2'b01;
        resp_ready_i = 2'b01;
        for (int s = 0; s < 4; s++) begin
            #1;
            chk("bp_valid", 32'(resp_valid_o), 32'b10);
            chk("bp_result", resp_result_o, 32'd81);
            chk("bp_req0_blocked", 32'(req_ready_o), 32'd0);
            @(negedge clk);
        end
        resp_ready_i = 2'b10;
        #1 chk("bp_hs_blocked", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        resp_ready_i = '0;
        #1 chk("bp_req0_grant", 32'(req_ready_o), 32'b01);
        @(posedge clk);
        #1 req_valid_i = '0;
        @(negedge clk);
        chk("bp_req0_a", mul_op_a_o, 32'd2);
        mul_ready_i  = 1'b1;
        mul_result_i = 32'd4;
        @(negedge clk);
        mul_ready_i  = 1'b0;
        chk("bp_req0_resp", 32'(resp_valid_o), 32'b01);
        chk("bp_req0_result", resp_result_o, 32'd4);
        resp_ready_i = 2'b01;
        @(negedge clk);
        resp_ready_i = '0;

        // Reset while BUSY: transaction is dropped without any response.
        req_valid_i = 2'b01;
        req_op_a_i  = {32'd0, 32'd5};
        @(posedge clk);
        #1 req_valid_i = '0;
        @(negedge clk);
        chk("mid_busy_en", 32'(mul_enable_o), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_en", 32'(mul_enable_o), 32'd0);
        chk("mid_rst_op_a", mul_op_a_o, 32'd0);
        chk("mid_rst_grant", 32'(grant_idx_o), 32'd0);
        rst_n        = 1'b1;
        mul_ready_i  = 1'b1;
        mul_result_i = 32'd99;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            mul_ready_i = 1'b0;
            chk("mid_no_resp", 32'(resp_valid_o), 32'd0);
            chk("mid_idle", 32'(busy_o), 32'd0);
        end

        // Multiplier never answers.
        req_valid_i = 2'b01;
        @(posedge clk);
        #1 req_valid_i = '0;
`ifdef MUL_ARB_TIMEOUT_EN
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("to_busy_en", 32'(mul_enable_o), 32'd1);
        end
        @(negedge clk);
        chk("to_valid", 32'(resp_valid_o), 32'b01);
        chk("to_result", resp_result_o, 32'hDEAD_BEEF);
        chk("to_err", 32'(resp_err_o), 32'd1);
        chk("to_en_low", 32'(mul_enable_o), 32'd0);
        resp_ready_i = 2'b01;
        @(negedge clk);
        resp_ready_i = '0;
        chk("to_err_clear", 32'(resp_err_o), 32'd0);
        chk("to_idle", 32'(busy_o), 32'd0);
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("hang_busy", 32'(busy_o), 32'd1);
            chk("hang_err", 32'(resp_err_o), 32'd0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("hang_reset", 32'(busy_o), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one cv32e40p multiplier between NUM_REQ independent requesters, for example the core EX stage and a vector or accelerator port.
- Arbitrates among requesters round-robin.
- Latches the winning operand set and holds it on the multiplier until the multiplier's ready.
- Returns the result to the winner over a valid/ready response channel.
- Sits between the requesters and the multiplier's enable/ready interface.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
OP_W, 3, multiplier operator width (mul_opcode_e)
TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
req_operator_i  in  NUM_REQ*OP_W  packed operator, slice i = requester i
req_op_a_i / req_op_b_i / req_op_c_i  in  NUM_REQ*32  packed operands
req_imm_i  in  NUM_REQ*5  packed immediate
req_short_signed_i  in  NUM_REQ*2  packed signedness
resp_valid_o  out  NUM_REQ  one-hot response valid
resp_ready_i  in  NUM_REQ  per-requester response ready
resp_result_o  out  32  result for the requester flagged in resp_valid_o
resp_err_o  out  1  timeout error flag (tied 0 without the optional feature)
mul_enable_o  out  1  multiplier enable
mul_ex_ready_o  out  1  multiplier ex_ready
mul_operator_o  out  OP_W  to multiplier
mul_op_a_o / mul_op_b_o / mul_op_c_o  out  32  to multiplier
mul_imm_o  out  5  to multiplier
mul_short_signed_o  out  2  to multiplier
mul_result_i  in  32  multiplier result
mul_ready_i  in  1  multiplier result valid
busy_o  out  1  state != IDLE
grant_idx_o  out  $clog2(NUM_REQ)  index of current or last grant

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, rr pointer=NUM_REQ-1, grant_idx_o=0.
  - All *_valid, *_ready and mul_enable outputs are 0.
  - Latched operands and result registers are 0.
  - Reset mid-transaction abandons it silently; no response is produced.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req_valid_i is set, the grant goes to the first set bit searching from (rr+1) mod NUM_REQ upward, with wrap.
  - req_ready_o[g]=1 combinationally in the same cycle; that cycle is the accept handshake.
  - On accept, slice g is latched, grant_idx_o is set to g, rr is set to g, and next state is BUSY.
  - With no requests, stay in IDLE.
- BUSY:
  - mul_enable_o=1 and mul_ex_ready_o=1; mul_* operand outputs come from the latched registers and are stable for the whole state.
  - When mul_ready_i=1: capture mul_result_i, next state RESP. mul_enable_o drops the following cycle.
  - Multi-cycle ops (MULH) simply stay in BUSY until ready.
- RESP:
  - resp_valid_o[grant]=1 and resp_result_o holds the captured value.
  - Held until resp_ready_i[grant]=1; then next state is IDLE.
  - resp_ready_i of non-granted requesters is ignored.
- Latency: accept at cycle T, BUSY at T+1; with a single-cycle mul_ready at T+1, resp_valid is set at T+2. Minimum issue interval is 3 cycles.
- No request is accepted outside IDLE; req_ready_o=0 in BUSY and RESP.
- req_valid_i withdrawn before accept has no effect.
- Fairness: a continuously asserting requester is served at most once per NUM_REQ grants while others are pending.
- mul_operator_o, mul_imm_o and mul_short_signed_o are driven from the latch in all states; only mul_enable_o gates activity.

Optional Feature:
MUL_ARB_TIMEOUT_EN
- Defined: a cycle counter runs in BUSY. If mul_ready_i has not been seen after TIMEOUT cycles in BUSY:
  - force state to RESP with resp_result_o=32'hDEAD_BEEF and resp_err_o=1 while that response is valid;
  - mul_enable_o drops;
  - the counter clears on leaving BUSY.
- Undefined: no counter; resp_err_o is constant 0 and BUSY waits indefinitely.

Test Plan:
- Single op: req0 valid, operator MUL, a=7, b=6, mul model ready 1 cycle later returning 42 -> req_ready_o=01 at T, mul_enable_o high at T+1 with a=7, b=6, resp_valid_o=01 at T+2 with resp_result_o=42.
- Contention: req0 and req1 valid together after reset (rr=1) -> req0 granted first, then req1. With both held continuously, grants alternate 0,1,0,1 over 4 transactions.
- Multi-cycle: MULH with model ready after 5 cycles -> mul_enable_o high for exactly 5 cycles with constant operands; result 32'h0000_0001 returned.
- Response backpressure: resp_ready_i[1]=0 for 4 cycles -> resp_valid_o[1] and result held stable; req0 pending meanwhile sees req_ready_o=0; req0 is granted the cycle after the response handshake plus one (IDLE).
- Reset mid-BUSY: rst_n low during BUSY -> next cycle all outputs 0, state IDLE; no response emitted afterwards.
- Timeout (macro defined, TIMEOUT=8, model never ready) -> after 8 BUSY cycles resp_valid_o set with 32'hDEADBEEF and resp_err_o=1; without the macro busy_o stays 1.
